// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, ALU ops, error codes and controller states for the RPN calculator
package calc_pkg;
  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_MULT  = 4'd12;
  localparam logic [3:0] KEY_DIV   = 4'd13;
  localparam logic [3:0] KEY_ENTER = 4'd14;
  localparam logic [3:0] KEY_CLEAR = 4'd15;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_DIV0  = 3'd1,
    ERR_OVF   = 3'd2,
    ERR_UNDER = 3'd3,
    ERR_FULL  = 3'd4,
    ERR_DIGIT = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {ST_IDLE, ST_PUSH, ST_FETCH, ST_EXEC, ST_WAIT, ST_WRITE} state_e;

  function automatic op_e key_to_op(input logic [3:0] k);
    case (k)
      KEY_PLUS:  return OP_ADD;
      KEY_MINUS: return OP_SUB;
      KEY_MULT:  return OP_MUL;
      KEY_DIV:   return OP_DIV;
      default:   return OP_ADD;
    endcase
  endfunction
endpackage

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - calculator ALU: single-cycle add/sub/mul, DATA_W-cycle restoring divider
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  op_e                      op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     done,
  output logic signed [DATA_W-1:0] y,
  output logic                     err,
  output logic [2:0]               code
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] sum, diff;
  logic [2*DATA_W-1:0]    prod;
  logic                   add_ovf, sub_ovf, mul_ovf;
  logic [DATA_W-1:0]      abs_a, abs_b;
  logic [DATA_W-1:0]      rem, quo, dvs;
  logic [2*DATA_W-1:0]    first_step, next_step;
  logic [CNT_W-1:0]       cnt;
  logic                   busy, neg_q;

  // One restoring step on the {remainder, dividend} pair; quotient bits shift in at the bottom.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] r,
                                                   input logic [DATA_W-1:0] q,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W:0]   rs;
    logic [DATA_W-1:0] qs;
    rs = {r, q[DATA_W-1]};
    qs = {q[DATA_W-2:0], 1'b0};
    if (rs >= {1'b0, d}) begin
      rs    = rs - {1'b0, d};
      qs[0] = 1'b1;
    end
    return {rs[DATA_W-1:0], qs};
  endfunction

  assign sum        = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign diff       = {a[DATA_W-1], a} - {b[DATA_W-1], b};
  assign prod       = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign add_ovf    = sum[DATA_W] ^ sum[DATA_W-1];
  assign sub_ovf    = diff[DATA_W] ^ diff[DATA_W-1];
  assign mul_ovf    = prod[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod[DATA_W-1]}};
  assign abs_a      = a[DATA_W-1] ? -a : a;
  assign abs_b      = b[DATA_W-1] ? -b : b;
  assign first_step = div_step('0, abs_a, abs_b);
  assign next_step  = div_step(rem, quo, dvs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done  <= 1'b0;
      y     <= '0;
      err   <= 1'b0;
      code  <= ERR_NONE;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        err  <= 1'b0;
        code <= ERR_NONE;
        case (op)
          OP_ADD: begin
            y    <= sum[DATA_W-1:0];
            done <= 1'b1;
            if (add_ovf) begin err <= 1'b1; code <= ERR_OVF; end
          end
          OP_SUB: begin
            y    <= diff[DATA_W-1:0];
            done <= 1'b1;
            if (sub_ovf) begin err <= 1'b1; code <= ERR_OVF; end
          end
          OP_MUL: begin
            y    <= prod[DATA_W-1:0];
            done <= 1'b1;
            if (mul_ovf) begin err <= 1'b1; code <= ERR_OVF; end
          end
          default: begin
            // The first quotient bit is resolved on the start edge so the divide takes DATA_W edges.
            {rem, quo} <= first_step;
            dvs        <= abs_b;
            neg_q      <= a[DATA_W-1] ^ b[DATA_W-1];
            cnt        <= CNT_W'(DATA_W - 1);
            busy       <= 1'b1;
            if (b == '0) begin
              err <= 1'b1; code <= ERR_DIV0;
            end else if (a == MIN_VAL && b == '1) begin
              err <= 1'b1; code <= ERR_OVF;
            end
          end
        endcase
      end else if (busy) begin
        {rem, quo} <= next_step;
        cnt        <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          y    <= neg_q ? -next_step[DATA_W-1:0] : next_step[DATA_W-1:0];
        end
      end
    end
  end
endmodule

// File: rtl/rpn_calc_ctrl.sv
// rtl/rpn_calc_ctrl.sv - RPN calculator controller: key entry, operand stack, ALU sequencing
module rpn_calc_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_W      = 36,
  parameter int MAX_DIGITS  = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               key_valid,
  input  logic [3:0]                         key,
  output logic                               key_ready,
  output logic signed [DATA_W-1:0]           disp,
  output logic                               disp_upd,
  output logic                               err,
  output logic [2:0]                         err_code,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [63:0] MAX_ENTRY = (64'd10 ** MAX_DIGITS) - 64'd1;
  localparam logic [63:0] POS_LIMIT = 64'd1 << (DATA_W - 1);

  if (MAX_ENTRY >= POS_LIMIT || STACK_DEPTH < 2) begin : g_param_check
    $error("rpn_calc_ctrl: MAX_DIGITS does not fit DATA_W or STACK_DEPTH < 2");
  end

  state_e                   state, state_n;
  logic signed [DATA_W-1:0] stk [STACK_DEPTH];
  logic signed [DATA_W-1:0] acc, acc_next, a_r, b_r, alu_y;
  logic [CNT_W-1:0]         cnt;
  op_e                      op_r;
  logic                     accept, is_digit, is_op, full, alu_start, alu_done, alu_err;
  logic [2:0]               alu_code;
  logic [PTR_W-1:0]         wr_idx, top_idx, sec_idx;

  assign key_ready = (state == ST_IDLE);
  assign accept    = key_valid && key_ready;
  assign is_digit  = key < 4'd10;
  assign is_op     = key >= KEY_PLUS && key <= KEY_DIV;
  assign full      = depth == DEPTH_W'(STACK_DEPTH);
  assign wr_idx    = PTR_W'(depth);
  assign top_idx   = PTR_W'(depth - DEPTH_W'(1));
  assign sec_idx   = PTR_W'(depth - DEPTH_W'(2));
  assign acc_next  = acc * DATA_W'(10) + DATA_W'(key);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    alu_start = 1'b0;
    case (state)
      ST_IDLE:  if (accept && is_op) state_n = (cnt != '0) ? ST_PUSH : ST_FETCH;
      ST_PUSH:  state_n = full ? ST_IDLE : ST_FETCH;
      ST_FETCH: state_n = (depth < DEPTH_W'(2)) ? ST_IDLE : ST_EXEC;
      ST_EXEC:  begin alu_start = 1'b1; state_n = ST_WAIT; end
      ST_WAIT:  if (alu_done) state_n = ST_WRITE;
      ST_WRITE: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
      depth    <= '0;
      acc      <= '0;
      cnt      <= '0;
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      disp     <= '0;
      disp_upd <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      disp_upd <= 1'b0;
      if (accept) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      case (state)
        ST_IDLE: if (accept) begin
          if (is_digit) begin
            if (cnt < CNT_W'(MAX_DIGITS)) begin
              acc      <= acc_next;
              cnt      <= cnt + CNT_W'(1);
              disp     <= acc_next;
              disp_upd <= 1'b1;
            end else begin
              err <= 1'b1; err_code <= ERR_DIGIT;
            end
          end else if (key == KEY_ENTER) begin
            if (full) begin
              err <= 1'b1; err_code <= ERR_FULL;
            end else begin
              // Pending entry wins; otherwise duplicate the top, or push zero on an empty stack.
              stk[wr_idx] <= (cnt != '0) ? acc : ((depth != '0) ? stk[top_idx] : '0);
              depth       <= depth + DEPTH_W'(1);
              acc         <= '0;
              cnt         <= '0;
            end
          end else if (key == KEY_CLEAR) begin
            depth    <= '0;
            acc      <= '0;
            cnt      <= '0;
            disp     <= '0;
            disp_upd <= 1'b1;
          end else begin
            op_r <= key_to_op(key);
          end
        end
        ST_PUSH: begin
          if (full) begin
            err <= 1'b1; err_code <= ERR_FULL;
          end else begin
            stk[wr_idx] <= acc;
            depth       <= depth + DEPTH_W'(1);
            acc         <= '0;
            cnt         <= '0;
          end
        end
        ST_FETCH: begin
          if (depth < DEPTH_W'(2)) begin
            err <= 1'b1; err_code <= ERR_UNDER;
          end else begin
            b_r <= stk[top_idx];
            a_r <= stk[sec_idx];
          end
        end
        ST_WRITE: begin
          if (alu_err) begin
            err <= 1'b1; err_code <= alu_code;
          end else begin
            stk[sec_idx] <= alu_y;
            depth        <= depth - DEPTH_W'(1);
            disp         <= alu_y;
            disp_upd     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .clk   (clk),
    .reset (reset),
    .start (alu_start),
    .op    (op_r),
    .a     (a_r),
    .b     (b_r),
    .done  (alu_done),
    .y     (alu_y),
    .err   (alu_err),
    .code  (alu_code)
  );
endmodule
